spi_serf: RTL and testbench

- SPI responder (serf) that terminates a 16-bit full-duplex SPI frame driven by the inertial interface's SPI master.
- Used as a synthesizable stand-in for the iNEMO sensor side, and as the on-chip endpoint for a second-board link.
- Receives the command or write word on MOSI and returns a preloaded response word on MISO in the same frame.
- Flags a completed frame with `rdy`, and a malformed frame with `frm_err`.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_serf_if.sv | 13 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/spi_serf.sv | 116 +++++++++++
 tb/tb_spi_serf.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI serf types and widths, plus iNEMO register addresses used to
// build realistic command words.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_serf_state_t;

  localparam int SPI_WIDTH = 16;

  localparam logic [6:0] INEMO_WHO_AM_I = 7'h0F;
  localparam logic [6:0] INEMO_CTRL1_XL = 7'h10;
  localparam logic [6:0] INEMO_CTRL2_G  = 7'h11;
  localparam logic [6:0] INEMO_OUTX_L_G = 7'h22;
  localparam logic [6:0] INEMO_OUTX_L_XL = 7'h28;

endpackage

// File: rtl/spi_serf_if.sv
// Host-side word interface of the SPI serf: response load, received word,
// ready level and frame-error pulse.
interface spi_serf_if #(parameter int WIDTH = spi_pkg::SPI_WIDTH);
  logic [WIDTH-1:0] tx_data;
  logic             wrt;
  logic             clr_rdy;
  logic [WIDTH-1:0] rx_data;
  logic             rdy;
  logic             frm_err;

  modport master (output tx_data, wrt, clr_rdy, input rx_data, rdy, frm_err);
  modport slave  (input tx_data, wrt, clr_rdy, output rx_data, rdy, frm_err);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop; reports the synced level and
// its rising/falling edges.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic ff1, ff2, ff3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
      ff3 <= RST_VAL;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign level = ff2;
  assign rise  = ff2 & ~ff3;
  assign fall  = ~ff2 & ff3;
endmodule

// File: rtl/spi_serf.sv
// SPI responder: shifts in one WIDTH-bit frame on MOSI while returning the
// preloaded holding word on MISO; flags good frames (rdy) and bad counts.
module spi_serf
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output wire        MISO,
  spi_serf_if.slave  host
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  logic ss_level, ss_rise, ss_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge_det #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(MOSI),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{ss_level, sclk_level, sclk_fall, mosi_rise, mosi_fall};

  spi_serf_state_t  state, state_nxt;
  logic [WIDTH-1:0] shft, shft_nxt;
  logic [WIDTH-1:0] tx_hold;
  logic [WIDTH-1:0] rx_q, rx_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             rdy_q, rdy_nxt;
  logic             err_q, err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shft    <= '0;
      bit_cnt <= '0;
      rx_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shft    <= shft_nxt;
      bit_cnt <= cnt_nxt;
      rx_q    <= rx_nxt;
      rdy_q   <= rdy_nxt;
      err_q   <= err_nxt;
    end
  end

  // The holding word is independent of the frame; it is copied into the
  // shifter only at frame start, so mid-frame writes wait for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n)         tx_hold <= '0;
    else if (host.wrt)  tx_hold <= host.tx_data;
  end

  always_comb begin
    state_nxt = state;
    shft_nxt  = shft;
    cnt_nxt   = bit_cnt;
    rx_nxt    = rx_q;
    rdy_nxt   = rdy_q & ~host.clr_rdy;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          shft_nxt  = tx_hold;
          cnt_nxt   = '0;
          rdy_nxt   = 1'b0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          shft_nxt = {shft[WIDTH-2:0], mosi_s};
          if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
        end
        // Close on the updated count so a coincident final edge still counts.
        if (ss_rise) begin
          state_nxt = IDLE;
          if (cnt_nxt == CNT_FULL) begin
            rx_nxt  = shft_nxt;
            rdy_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign host.rx_data = rx_q;
  assign host.rdy     = rdy_q;
  assign host.frm_err = err_q;

  assign MISO = SS_n ? 1'bz : shft[WIDTH-1];
endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a bit-banged SPI master runs a table of frames, each
// frame's expected result is queued at drive time and checked after SS_n rise.
module tb_spi_serf;
  import spi_pkg::*;

  localparam int W  = SPI_WIDTH;
  localparam int HP = 6;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic SCLK = 1'b1;
  logic MOSI = 1'b0;
  wire  MISO;

  // A released MISO reads as 1 through the pullup.
  pullup (MISO);

  spi_serf_if #(.WIDTH(W)) hif ();

  spi_serf #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO), .host(hif)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int err_cnt = 0;

  always @(posedge clk) if (hif.frm_err === 1'b1) err_cnt++;

  typedef struct {
    logic        do_wrt;
    logic [15:0] tx;
    logic [15:0] mosi;
    int          nbits;
    int          wrt_bit;
    logic [15:0] wrt_val;
    logic        clr_end;
    logic        chk_miso;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_rdy;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic        chk_miso;
    logic [15:0] miso;
    logic [15:0] rx;
    logic        rdy_mid;
    logic        rdy;
    int          err;
  } res_t;

  res_t sbq[$];
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_hold(input logic [15:0] val);
    hif.tx_data = val;
    hif.wrt = 1'b1;
    tick(1);
    hif.wrt = 1'b0;
  endtask

  // Master drives MOSI on SCLK fall and samples MISO at SCLK rise.
  task automatic sclk_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    tick(HP);
    SCLK = 1'b1;
    m = MISO;
    tick(HP);
  endtask

  task automatic frame(input vec_t v, output res_t r);
    int          e0;
    logic        m;
    logic [15:0] mi;
    logic [15:0] mo;
    e0 = err_cnt;
    mi = '0;
    mo = v.mosi;
    r.chk_miso = v.chk_miso;
    r.rdy_mid = 1'bx;
    SS_n = 1'b0;
    tick(HP);
    for (int i = 0; i < v.nbits; i++) begin
      sclk_bit(mo[15], m);
      mo = mo << 1;
      mi = {mi[14:0], m};
      if (i == 0) r.rdy_mid = hif.rdy;
      if (i == v.wrt_bit) write_hold(v.wrt_val);
    end
    SS_n = 1'b1;
    tick(2);
    hif.clr_rdy = v.clr_end;
    tick(1);
    hif.clr_rdy = 1'b0;
    tick(1);
    r.miso = mi;
    r.rx   = hif.rx_data;
    r.rdy  = hif.rdy;
    tick(3);
    r.err  = err_cnt - e0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    res_t e;
    res_t got;
    e.chk_miso = v.chk_miso;
    e.miso = v.exp_miso;
    e.rx = v.exp_rx;
    e.rdy_mid = 1'b0;
    e.rdy = v.exp_rdy;
    e.err = v.exp_err;
    if (v.do_wrt) write_hold(v.tx);
    sbq.push_back(e);
    frame(v, got);
    e = sbq.pop_front();
    if (e.chk_miso) chk({nm, " miso"}, 32'(got.miso), 32'(e.miso));
    chk({nm, " rx_data"}, 32'(got.rx), 32'(e.rx));
    chk({nm, " rdy_start"}, 32'(got.rdy_mid), 32'(e.rdy_mid));
    chk({nm, " rdy"}, 32'(got.rdy), 32'(e.rdy));
    chk({nm, " frm_err"}, 32'(got.err), 32'(e.err));
  endtask

  function automatic vec_t mk(input logic do_wrt, input logic [15:0] tx,
                              input logic [15:0] mosi, input int nbits,
                              input int wrt_bit, input logic [15:0] wrt_val,
                              input logic clr_end, input logic chk_miso,
                              input logic [15:0] exp_miso, input logic [15:0] exp_rx,
                              input logic exp_rdy, input int exp_err);
    vec_t v;
    v.do_wrt = do_wrt;   v.tx = tx;           v.mosi = mosi;
    v.nbits = nbits;     v.wrt_bit = wrt_bit; v.wrt_val = wrt_val;
    v.clr_end = clr_end; v.chk_miso = chk_miso;
    v.exp_miso = exp_miso; v.exp_rx = exp_rx;
    v.exp_rdy = exp_rdy; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    logic        m;
    int          e0;
    logic [15:0] mo;
    vec_t        clean;

    hif.tx_data = '0;
    hif.wrt = 1'b0;
    hif.clr_rdy = 1'b0;

    // full duplex, back-to-back, short/long, mid-frame wrt, clr_rdy at frame end
    vt[0] = mk(1, 16'hA55A, {1'b1, INEMO_WHO_AM_I, 8'h00}, 16, -1, 0, 0, 1, 16'hA55A, 16'h8F00, 1, 0);
    vt[1] = mk(0, 0, 16'h1234, 16, -1, 0, 0, 1, 16'hA55A, 16'h1234, 1, 0);
    vt[2] = mk(0, 0, 16'hFFFF, 16, -1, 0, 0, 1, 16'hA55A, 16'hFFFF, 1, 0);
    vt[3] = mk(0, 0, 16'h0F0F, 15, -1, 0, 0, 0, 0, 16'hFFFF, 0, 1);
    vt[4] = mk(0, 0, 16'h0F0F, 17, -1, 0, 0, 0, 0, 16'hFFFF, 0, 1);
    vt[5] = mk(1, 16'hC3C3, {1'b0, INEMO_CTRL1_XL, 8'h60}, 16, 5, 16'h00FF, 0, 1, 16'hC3C3, 16'h1060, 1, 0);
    vt[6] = mk(0, 0, {1'b1, INEMO_OUTX_L_G, 8'h00}, 16, -1, 0, 1, 1, 16'h00FF, 16'hA200, 1, 0);

    // Reset: outputs cleared and MISO released while SS_n is high.
    tick(2);
    chk("reset rdy", 32'(hif.rdy), 32'd0);
    chk("reset frm_err", 32'(hif.frm_err), 32'd0);
    chk("reset rx_data", 32'(hif.rx_data), 32'h0);
    chk("reset miso released", 32'(MISO), 32'd1);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // rdy is a level until clr_rdy.
    chk("rdy held", 32'(hif.rdy), 32'd1);
    hif.clr_rdy = 1'b1;
    tick(1);
    hif.clr_rdy = 1'b0;
    tick(1);
    chk("clr_rdy clears", 32'(hif.rdy), 32'd0);

    // Reset after bit 8, released with SS_n still low. The SS_n chain resets
    // high, so the low pin yields one SS_fall, a 8-bit frame and one frm_err.
    e0 = err_cnt;
    mo = 16'h5A5A;
    SS_n = 1'b0;
    tick(HP);
    for (int i = 0; i < 8; i++) begin sclk_bit(mo[15], m); mo = mo << 1; end
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("midrst rx_data", 32'(hif.rx_data), 32'h0);
    for (int i = 0; i < 8; i++) begin sclk_bit(mo[15], m); mo = mo << 1; end
    SS_n = 1'b1;
    tick(8);
    chk("midrst frm_err", 32'(err_cnt - e0), 32'd1);
    chk("midrst rdy", 32'(hif.rdy), 32'd0);
    chk("midrst rx_kept", 32'(hif.rx_data), 32'h0);

    // Clean frame afterwards; holding register was reset to 0.
    clean = mk(0, 0, 16'h5A5A, 16, -1, 0, 0, 1, 16'h0000, 16'h5A5A, 1, 0);
    run_vec("post_rst", clean);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
